// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: major opcodes, the canonical NOP, immediate
// format selector, the decoded control bundle and the immediate generator.
package rv32_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic alu_src;
        logic mem_to_reg;
    } ctrl_t;

    // Assemble the sign-extended immediate for the given format.
    function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_type_t fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// 32x32 integer register file: two combinational read ports, one write port
// on posedge, synchronous active-low clear. x0 is hard-wired to zero.
// Optional macro ID_WB_BYPASS_EN: a write in the current cycle is forwarded
// straight to a read port addressing the same register.
module register_file
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);

    logic [31:0] regs [32];
    logic        wr_en;

    assign wr_en = we && (waddr != 5'd0);

    // Storage update: clear everything on reset, otherwise write non-x0 targets.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'b0;
            end
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports: x0 forced to zero, optional same-cycle write-through.
    always_comb begin
        rdata_a = (raddr_a == 5'd0) ? 32'b0 : regs[raddr_a];
        rdata_b = (raddr_b == 5'd0) ? 32'b0 : regs[raddr_b];
`ifdef ID_WB_BYPASS_EN
        if (wr_en && (waddr == raddr_a)) rdata_a = wdata;
        if (wr_en && (waddr == raddr_b)) rdata_b = wdata;
`else
        // Without the bypass a same-cycle write is visible from the next cycle.
`endif
    end

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: IF/ID register, register file, main decoder and
// load-use hazard detection.
// Optional macro ID_WB_BYPASS_EN (consumed by register_file) enables
// WB->ID write-through on register reads.
//
// Flow control: pcWrite acts as the stage's ready toward fetch. When it is
// low, fetch must hold its PC and the IF/ID register holds its contents; the
// stage simultaneously emits a bubble (all controls 0) toward EX. flush
// overrides a stall and replaces the IF/ID contents with an invalid NOP.
module instruction_decode
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instruction,
    input  logic        flush,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        pcWrite,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [4:0]  id_rd,
    output logic [31:0] id_rs1_data,
    output logic [31:0] id_rs2_data,
    output logic [31:0] id_imm,
    output logic [2:0]  id_funct3,
    output logic        id_funct7b5,
    output logic [6:0]  id_opcode,
    output logic        id_reg_write,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_branch,
    output logic        id_jump,
    output logic        id_alu_src,
    output logic        id_mem_to_reg
);

    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    imm_type_t   imm_type;
    logic        imm_known;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        stall;
    ctrl_t       dec_ctrl;
    ctrl_t       out_ctrl;

    assign opcode = if_id_instr[6:0];
    assign rs1    = if_id_instr[19:15];
    assign rs2    = if_id_instr[24:20];

    // IF/ID register: reset > flush > stall hold > load from fetch.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            if_id_pc    <= RESET_PC;
            if_id_instr <= NOP;
            if_id_valid <= 1'b0;
        end else if (flush) begin
            if_id_instr <= NOP;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if_id_pc    <= if_pc;
            if_id_instr <= if_instruction;
            if_id_valid <= 1'b1;
        end
    end

    // Main decoder: per-opcode controls, immediate format and source usage.
    always_comb begin
        dec_ctrl  = '0;
        imm_type  = IMM_I;
        imm_known = 1'b0;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        case (opcode)
            OP: begin
                dec_ctrl.reg_write = 1'b1;
                uses_rs2           = 1'b1;
            end
            OP_IMM: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                imm_known          = 1'b1;
            end
            LOAD: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                imm_known           = 1'b1;
            end
            STORE: begin
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                imm_type           = IMM_S;
                imm_known          = 1'b1;
                uses_rs2           = 1'b1;
            end
            BRANCH: begin
                dec_ctrl.branch = 1'b1;
                imm_type        = IMM_B;
                imm_known       = 1'b1;
                uses_rs2        = 1'b1;
            end
            JAL: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.jump      = 1'b1;
                imm_type           = IMM_J;
                imm_known          = 1'b1;
                uses_rs1           = 1'b0;
            end
            JALR: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.jump      = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                imm_known          = 1'b1;
            end
            LUI, AUIPC: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                imm_type           = IMM_U;
                imm_known          = 1'b1;
                uses_rs1           = 1'b0;
            end
            default: begin
                dec_ctrl = '0;
            end
        endcase
    end

    // Load-use hazard: the load in EX writes a register this instruction reads.
    always_comb begin
        stall = if_id_valid && ex_mem_read && (ex_rd != 5'd0) &&
                ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)));
        pcWrite = !stall;
    end

    // Bubble insertion toward EX when stalled or holding no instruction.
    always_comb begin
        out_ctrl = dec_ctrl;
        if (stall || !if_id_valid) out_ctrl = '0;
    end

    register_file u_register_file (
        .clk     (clk),
        .resetn  (resetn),
        .we      (wb_reg_write),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr_a (rs1),
        .raddr_b (rs2),
        .rdata_a (id_rs1_data),
        .rdata_b (id_rs2_data)
    );

    assign id_valid      = if_id_valid;
    assign id_pc         = if_id_pc;
    assign id_rs1        = rs1;
    assign id_rs2        = rs2;
    assign id_rd         = if_id_instr[11:7];
    assign id_imm        = imm_known ? gen_imm(if_id_instr, imm_type) : 32'b0;
    assign id_funct3     = if_id_instr[14:12];
    assign id_funct7b5   = if_id_instr[30];
    assign id_opcode     = opcode;
    assign id_reg_write  = out_ctrl.reg_write;
    assign id_mem_read   = out_ctrl.mem_read;
    assign id_mem_write  = out_ctrl.mem_write;
    assign id_branch     = out_ctrl.branch;
    assign id_jump       = out_ctrl.jump;
    assign id_alu_src    = out_ctrl.alu_src;
    assign id_mem_to_reg = out_ctrl.mem_to_reg;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed testbench for instruction_decode. Expected values are hand-computed
// from the RV32I encodings; the writeback expectations follow ID_WB_BYPASS_EN.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        flush;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        pcWrite;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [2:0]  id_funct3;
    logic        id_funct7b5;
    logic [6:0]  id_opcode;
    logic        id_reg_write, id_mem_read, id_mem_write, id_branch;
    logic        id_jump, id_alu_src, id_mem_to_reg;
    logic [6:0]  ctrl;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    // {reg_write, mem_read, mem_write, branch, jump, alu_src, mem_to_reg}
    assign ctrl = {id_reg_write, id_mem_read, id_mem_write, id_branch,
                   id_jump, id_alu_src, id_mem_to_reg};

    instruction_decode #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .flush          (flush),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .wb_reg_write   (wb_reg_write),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .pcWrite        (pcWrite),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .id_rs1_data    (id_rs1_data),
        .id_rs2_data    (id_rs2_data),
        .id_imm         (id_imm),
        .id_funct3      (id_funct3),
        .id_funct7b5    (id_funct7b5),
        .id_opcode      (id_opcode),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .id_mem_write   (id_mem_write),
        .id_branch      (id_branch),
        .id_jump        (id_jump),
        .id_alu_src     (id_alu_src),
        .id_mem_to_reg  (id_mem_to_reg)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
        if_pc          = pc;
        if_instruction = instr;
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    // Immediate / control vector table
    localparam int N_VEC = 7;
    logic [31:0] vec_instr [N_VEC] = '{32'hFE000EE3, 32'h001000EF, 32'hFE20AC23,
                                       32'h01012203, 32'h12345097, 32'hFFFFFFFF,
                                       32'h00500093};
    logic [31:0] vec_imm   [N_VEC] = '{32'hFFFFFFFC, 32'h00000800, 32'hFFFFFFF8,
                                       32'h00000010, 32'h12345000, 32'h00000000,
                                       32'h00000005};
    logic [6:0]  vec_ctrl  [N_VEC] = '{7'b0001000, 7'b1000100, 7'b0010010,
                                       7'b1100011, 7'b1000010, 7'b0000000,
                                       7'b1000010};

    logic [31:0] wb_exp;

    initial begin
        resetn = 1'b0; flush = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
        wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = 32'b0;
        fetch(32'h0, 32'h0000_0013);
        tick(); tick();
        resetn = 1'b1;

        // Fill the register file so the later reset has something to clear.
        for (int r = 1; r < 32; r++) begin
            wb_reg_write = 1'b1; wb_rd = 5'(r); wb_data = 32'hA5A5_0000 | 32'(r);
            tick();
        end
        wb_reg_write = 1'b0;
        fetch(32'h4, enc_r(5'd0, 5'd7, 5'd9));
        tick();
        check("rf_fill_rs1", id_rs1_data, 32'hA5A5_0007);
        check("rf_fill_rs2", id_rs2_data, 32'hA5A5_0009);

        // Reset for two cycles.
        resetn = 1'b0;
        tick(); tick();
        check("rst_valid", {31'b0, id_valid}, 32'd0);
        check("rst_pc", id_pc, 32'h0);
        check("rst_ctrl", {25'b0, ctrl}, 32'd0);
        check("rst_pcwrite", {31'b0, pcWrite}, 32'd1);
        check("rst_opcode", {25'b0, id_opcode}, 32'h13);
        resetn = 1'b1;

        // Every register reads zero after reset.
        for (int r = 1; r < 32; r++) begin
            fetch(32'(r * 4), enc_r(5'd0, 5'(r), 5'(r)));
            exp_q.push_back(32'b0);
            tick();
            check("rf_reset_rs1", id_rs1_data, exp_q[0]);
            check("rf_reset_rs2", id_rs2_data, exp_q.pop_front());
        end

        // Normal fetch: addi x1, x0, 5
        fetch(32'h10, 32'h0050_0093);
        tick();
        check("fetch_valid", {31'b0, id_valid}, 32'd1);
        check("fetch_pc", id_pc, 32'h10);
        check("fetch_rd", {27'b0, id_rd}, 32'd1);
        check("fetch_imm", id_imm, 32'd5);
        check("fetch_ctrl", {25'b0, ctrl}, {25'b0, 7'b1000010});

        // Load-use on rs1: add x3, x1, x2 with a load to x1 in EX.
        fetch(32'h20, 32'h0020_81B3);
        tick();
        ex_mem_read = 1'b1; ex_rd = 5'd1;
        fetch(32'h24, 32'h0050_0093);
        settle();
        check("lu_pcwrite", {31'b0, pcWrite}, 32'd0);
        check("lu_ctrl", {25'b0, ctrl}, 32'd0);
        check("lu_rs1_idx", {27'b0, id_rs1}, 32'd1);
        tick();
        check("lu_hold_pc", id_pc, 32'h20);
        check("lu_hold_rd", {27'b0, id_rd}, 32'd3);
        ex_mem_read = 1'b0;
        settle();
        check("lu_resume_pcwrite", {31'b0, pcWrite}, 32'd1);
        check("lu_resume_ctrl", {25'b0, ctrl}, {25'b0, 7'b1000000});
        tick();
        check("lu_next_pc", id_pc, 32'h24);

        // Load-use on rs2.
        fetch(32'h28, 32'h0020_81B3);
        tick();
        ex_mem_read = 1'b1; ex_rd = 5'd2;
        settle();
        check("lu_rs2_pcwrite", {31'b0, pcWrite}, 32'd0);
        ex_mem_read = 1'b0;

        // ex_rd = x0 never stalls; I-type does not use the rs2 field.
        fetch(32'h2C, 32'h0050_0093);
        tick();
        ex_mem_read = 1'b1; ex_rd = 5'd0;
        settle();
        check("lu_x0_pcwrite", {31'b0, pcWrite}, 32'd1);
        ex_rd = 5'd5;
        settle();
        check("lu_itype_rs2_pcwrite", {31'b0, pcWrite}, 32'd1);
        ex_mem_read = 1'b0;

        // LUI x1 whose rs1 field is 1: no source use, no stall.
        fetch(32'h30, 32'h0000_80B7);
        tick();
        ex_mem_read = 1'b1; ex_rd = 5'd1;
        settle();
        check("lui_pcwrite", {31'b0, pcWrite}, 32'd1);
        check("lui_imm", id_imm, 32'h0000_8000);
        check("lui_ctrl", {25'b0, ctrl}, {25'b0, 7'b1000010});
        ex_mem_read = 1'b0;

        // Flush wins over stall.
        fetch(32'h34, 32'h0020_81B3);
        tick();
        ex_mem_read = 1'b1; ex_rd = 5'd1; flush = 1'b1;
        settle();
        check("fl_stall_seen", {31'b0, pcWrite}, 32'd0);
        tick();
        flush = 1'b0; ex_mem_read = 1'b0;
        settle();
        check("fl_valid", {31'b0, id_valid}, 32'd0);
        check("fl_opcode", {25'b0, id_opcode}, 32'h13);
        check("fl_rd", {27'b0, id_rd}, 32'd0);
        check("fl_ctrl", {25'b0, ctrl}, 32'd0);
        check("fl_pcwrite", {31'b0, pcWrite}, 32'd1);
        tick();
        check("fl_recover_valid", {31'b0, id_valid}, 32'd1);
        check("fl_recover_pc", id_pc, 32'h34);

        // Reset asserted mid-stall.
        ex_mem_read = 1'b1; ex_rd = 5'd1;
        settle();
        check("rs_stall_seen", {31'b0, pcWrite}, 32'd0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        settle();
        check("rs_valid", {31'b0, id_valid}, 32'd0);
        check("rs_pcwrite", {31'b0, pcWrite}, 32'd1);
        check("rs_pc", id_pc, 32'h0);
        ex_mem_read = 1'b0;

        // Immediate formats and controls.
        for (int i = 0; i < N_VEC; i++) begin
            fetch(32'h100 + 32'(i * 4), vec_instr[i]);
            tick();
            check("imm_value", id_imm, vec_imm[i]);
            check("imm_ctrl", {25'b0, ctrl}, {25'b0, vec_ctrl[i]});
        end

        // Writeback to x5 while ID reads x5 (old value 0).
        fetch(32'h200, enc_r(5'd3, 5'd5, 5'd0));
        tick();
        wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        settle();
`ifdef ID_WB_BYPASS_EN
        wb_exp = 32'hDEAD_BEEF;
`else
        wb_exp = 32'h0;
`endif
        check("wb_same_cycle", id_rs1_data, wb_exp);
        tick();
        wb_reg_write = 1'b0;
        settle();
        check("wb_next_cycle", id_rs1_data, 32'hDEAD_BEEF);

        // Overwrite x5 with a nonzero old value present.
        wb_reg_write = 1'b1; wb_data = 32'hCAFE_F00D;
        settle();
`ifdef ID_WB_BYPASS_EN
        wb_exp = 32'hCAFE_F00D;
`else
        wb_exp = 32'hDEAD_BEEF;
`endif
        check("wb2_same_cycle", id_rs1_data, wb_exp);
        tick();
        wb_reg_write = 1'b0;
        settle();
        check("wb2_next_cycle", id_rs1_data, 32'hCAFE_F00D);

        // Write to x0 is ignored; x0 reads zero.
        fetch(32'h204, enc_r(5'd3, 5'd0, 5'd5));
        wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234_5678;
        tick();
        check("wb_x0_same", id_rs1_data, 32'h0);
        check("wb_x0_rs2", id_rs2_data, 32'hCAFE_F00D);
        tick();
        wb_reg_write = 1'b0;
        settle();
        check("wb_x0_after", id_rs1_data, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
